// File: rtl/memory_requester.sv
// memory_requester
//   Bridges a host byte-write / byte-read interface to a memory manager.
//   Host writes are queued in a FIFO and issued one at a time as a
//   request/complete handshake. Host reads are issued one at a time. Each
//   read waits a fixed number of cycles before memoryReadData is sampled.
//   A read is only accepted once every queued write has fully retired, so
//   a read never overtakes an earlier write.
//
// Parameters
//   FIFO_DEPTH  write-queue entries (power of 2, >= 2)
//   READ_WAIT   cycles from memoryReadAddress drive to memoryReadData sample (>= 5)
//
// Ports
//   clock, resetN                      sole clock; async active-low reset
//   hostWrite{Valid,Address,Data}      host write offer; hostWriteReady = queue not full
//   hostRead{Valid,Address}            host read offer; hostReadReady = read can be accepted
//   hostReadData / hostReadDataValid   returned byte, one-cycle valid pulse
//   memoryWrite{Request,Address,Data}  write request to memory manager
//   memoryWriteComplete                one-cycle completion pulse from memory manager
//   memoryReadAddress / memoryReadData read address out, read byte in
//   busy                               queue non-empty or either FSM active
//
// Optional feature (macro MEMORY_REQUESTER_OVERFLOW_EN)
//   Adds output writeOverflow: sticky flag set when hostWriteValid is seen
//   while the queue is full. Cleared only by reset.

module memory_requester #(
  parameter int FIFO_DEPTH = 8,
  parameter int READ_WAIT  = 6
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        hostWriteValid,
  input  logic [16:0] hostWriteAddress,
  input  logic [7:0]  hostWriteData,
  output logic        hostWriteReady,
  input  logic        hostReadValid,
  input  logic [16:0] hostReadAddress,
  output logic        hostReadReady,
  output logic [7:0]  hostReadData,
  output logic        hostReadDataValid,
  output logic        memoryWriteRequest,
  output logic [16:0] memoryWriteAddress,
  output logic [7:0]  memoryWriteData,
  input  logic        memoryWriteComplete,
  output logic [16:0] memoryReadAddress,
  input  logic [7:0]  memoryReadData,
  output logic        busy
`ifdef MEMORY_REQUESTER_OVERFLOW_EN
  ,
  output logic        writeOverflow
`endif
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(READ_WAIT);

  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   WAIT_C  = CW'(READ_WAIT - 1);

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_GAP} w_state_e;
  typedef enum logic       {R_IDLE, R_WAIT}       r_state_e;

  // ---------------------------------------------------------------------
  // Write queue
  // ---------------------------------------------------------------------
  wr_entry_t           fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;
  wr_entry_t           head;
  logic                fifo_empty;
  logic                push, pop;

  w_state_e            w_state_q, w_state_d;
  logic                mw_req_q, mw_req_d;
  logic [16:0]         mw_addr_q, mw_addr_d;
  logic [7:0]          mw_data_q, mw_data_d;

  r_state_e            r_state_q, r_state_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [16:0]         mr_addr_q, mr_addr_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rd_accept;

  // Ready flags depend only on registered state; no input feeds them.
  assign fifo_empty     = (count_q == '0);
  assign hostWriteReady = (count_q < DEPTH_C);
  assign hostReadReady  = (r_state_q == R_IDLE) && fifo_empty && (w_state_q == W_IDLE);

  assign push      = hostWriteValid && hostWriteReady;
  assign pop       = (w_state_q == W_REQ) && memoryWriteComplete;
  assign rd_accept = hostReadValid && hostReadReady;
  assign head      = fifo_mem_q[rd_ptr_q];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {hostWriteAddress, hostWriteData};
  end

  // Power-of-2 depth: pointer increment wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_d = w_state_q;
    mw_req_d  = mw_req_q;
    mw_addr_d = mw_addr_q;
    mw_data_d = mw_data_q;
    case (w_state_q)
      W_IDLE: begin
        // Writes only start while no read is outstanding, so a read accepted
        // on the same edge as a push always goes first.
        if (!fifo_empty && (r_state_q == R_IDLE)) begin
          w_state_d = W_REQ;
          mw_req_d  = 1'b1;
          mw_addr_d = head.addr;
          mw_data_d = head.data;
        end
      end
      W_REQ: begin
        if (memoryWriteComplete) begin
          w_state_d = W_GAP;
          mw_req_d  = 1'b0;
        end
      end
      W_GAP:   w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  always_comb begin
    r_state_d  = r_state_q;
    wait_cnt_d = wait_cnt_q;
    mr_addr_d  = mr_addr_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rd_accept) begin
          r_state_d  = R_WAIT;
          mr_addr_d  = hostReadAddress;
          wait_cnt_d = WAIT_C;
        end
      end
      R_WAIT: begin
        if (wait_cnt_q == '0) begin
          r_state_d = R_IDLE;
          rdata_d   = memoryReadData;
          rvalid_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      w_state_q  <= W_IDLE;
      mw_req_q   <= 1'b0;
      mw_addr_q  <= '0;
      mw_data_q  <= '0;
      r_state_q  <= R_IDLE;
      wait_cnt_q <= '0;
      mr_addr_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      w_state_q  <= w_state_d;
      mw_req_q   <= mw_req_d;
      mw_addr_q  <= mw_addr_d;
      mw_data_q  <= mw_data_d;
      r_state_q  <= r_state_d;
      wait_cnt_q <= wait_cnt_d;
      mr_addr_q  <= mr_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign memoryWriteRequest = mw_req_q;
  assign memoryWriteAddress = mw_addr_q;
  assign memoryWriteData    = mw_data_q;
  assign memoryReadAddress  = mr_addr_q;
  assign hostReadData       = rdata_q;
  assign hostReadDataValid  = rvalid_q;
  assign busy = !fifo_empty || (w_state_q != W_IDLE) || (r_state_q != R_IDLE);

`ifdef MEMORY_REQUESTER_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (hostWriteValid && !hostWriteReady);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign writeOverflow = ovf_q;
`endif

endmodule

// File: tb/tb_memory_requester.sv
// Bench for memory_requester: directed scenarios plus a randomized run
// checked against a transaction-level model (queue of pending writes,
// outstanding-read timer).

module tb_memory_requester;
  localparam int FIFO_DEPTH = 8;
  localparam int READ_WAIT  = 6;

  logic        clock  = 1'b0;
  logic        resetN = 1'b1;
  logic        hostWriteValid;
  logic [16:0] hostWriteAddress;
  logic [7:0]  hostWriteData;
  logic        hostWriteReady;
  logic        hostReadValid;
  logic [16:0] hostReadAddress;
  logic        hostReadReady;
  logic [7:0]  hostReadData;
  logic        hostReadDataValid;
  logic        memoryWriteRequest;
  logic [16:0] memoryWriteAddress;
  logic [7:0]  memoryWriteData;
  logic        memoryWriteComplete;
  logic [16:0] memoryReadAddress;
  logic [7:0]  memoryReadData;
  logic        busy;
`ifdef MEMORY_REQUESTER_OVERFLOW_EN
  logic        writeOverflow;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } ent_t;

  memory_requester #(.FIFO_DEPTH(FIFO_DEPTH), .READ_WAIT(READ_WAIT)) dut (
    .clock              (clock),
    .resetN             (resetN),
    .hostWriteValid     (hostWriteValid),
    .hostWriteAddress   (hostWriteAddress),
    .hostWriteData      (hostWriteData),
    .hostWriteReady     (hostWriteReady),
    .hostReadValid      (hostReadValid),
    .hostReadAddress    (hostReadAddress),
    .hostReadReady      (hostReadReady),
    .hostReadData       (hostReadData),
    .hostReadDataValid  (hostReadDataValid),
    .memoryWriteRequest (memoryWriteRequest),
    .memoryWriteAddress (memoryWriteAddress),
    .memoryWriteData    (memoryWriteData),
    .memoryWriteComplete(memoryWriteComplete),
    .memoryReadAddress  (memoryReadAddress),
    .memoryReadData     (memoryReadData),
    .busy               (busy)
`ifdef MEMORY_REQUESTER_OVERFLOW_EN
    ,
    .writeOverflow      (writeOverflow)
`endif
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    hostWriteValid      = 1'b0;
    hostWriteAddress    = '0;
    hostWriteData       = '0;
    hostReadValid       = 1'b0;
    hostReadAddress     = '0;
    memoryWriteComplete = 1'b0;
    memoryReadData      = '0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    resetN = 1'b0;
    clear_inputs();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 resetN = 1'b0;
    #1;
    checks++;
    if ({hostWriteReady, hostReadReady, busy, memoryWriteRequest, hostReadDataValid} !== 5'b11000)
      $display("FAIL reset_flags: got %b want 11000",
               {hostWriteReady, hostReadReady, busy, memoryWriteRequest, hostReadDataValid});
    else passed++;
    checks++;
    if ({memoryWriteAddress, memoryWriteData, memoryReadAddress, hostReadData} !== 50'd0)
      $display("FAIL reset_data: got %h want 0",
               {memoryWriteAddress, memoryWriteData, memoryReadAddress, hostReadData});
    else passed++;
    @(negedge clock);
    resetN = 1'b1;
    tick();
    checks++;
    if ({hostWriteReady, hostReadReady, busy, memoryWriteRequest} !== 4'b1100)
      $display("FAIL reset_release: got %b want 1100",
               {hostWriteReady, hostReadReady, busy, memoryWriteRequest});
    else passed++;
  endtask

  task automatic test_write();
    apply_reset();
    hostWriteValid = 1'b1; hostWriteAddress = 17'h1ABCD; hostWriteData = 8'h5A;
    tick();
    hostWriteValid = 1'b0;
    checks++;
    if ({memoryWriteRequest, busy} !== 2'b01)
      $display("FAIL write_pushed: got %b want 01", {memoryWriteRequest, busy});
    else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({memoryWriteRequest, memoryWriteAddress, memoryWriteData} !== {1'b1, 17'h1ABCD, 8'h5A})
        $display("FAIL write_hold[%0d]: got %b/%h/%h want 1/1abcd/5a", i,
                 memoryWriteRequest, memoryWriteAddress, memoryWriteData);
      else passed++;
      if (i == 2) memoryWriteComplete = 1'b1;
      tick();
    end
    memoryWriteComplete = 1'b0;
    checks++;
    if ({memoryWriteRequest, busy, hostReadReady} !== 3'b010)
      $display("FAIL write_drop: got %b want 010", {memoryWriteRequest, busy, hostReadReady});
    else passed++;
    tick();
    checks++;
    if ({busy, hostReadReady} !== 2'b01)
      $display("FAIL write_idle: got %b want 01", {busy, hostReadReady});
    else passed++;
  endtask

  task automatic test_fifo_full();
    logic exp_rdy;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      hostWriteValid = 1'b1; hostWriteAddress = 17'h100 + 17'(i); hostWriteData = 8'(i);
      tick();
      exp_rdy = (i < 7);
      checks++;
      if (hostWriteReady !== exp_rdy)
        $display("FAIL full_ready[%0d]: got %b want %b", i, hostWriteReady, exp_rdy);
      else passed++;
`ifdef MEMORY_REQUESTER_OVERFLOW_EN
      if (i >= 7) begin
        checks++;
        if (writeOverflow !== (i == 8))
          $display("FAIL full_overflow[%0d]: got %b want %b", i, writeOverflow, (i == 8));
        else passed++;
      end
`endif
    end
    hostWriteValid = 1'b0;
    // Drain: entries must come out in push order; the rejected 9th never appears.
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      while (memoryWriteRequest !== 1'b1 && n < 10) begin tick(); n++; end
      checks++;
      if ({memoryWriteRequest, memoryWriteAddress, memoryWriteData} !== {1'b1, 17'h100 + 17'(i), 8'(i)})
        $display("FAIL drain[%0d]: got %b/%h/%h want 1/%h/%h", i, memoryWriteRequest,
                 memoryWriteAddress, memoryWriteData, 17'h100 + 17'(i), 8'(i));
      else passed++;
      memoryWriteComplete = 1'b1;
      tick();
      memoryWriteComplete = 1'b0;
    end
    tick();
    checks++;
    if ({busy, hostWriteReady, memoryWriteRequest} !== 3'b010)
      $display("FAIL drain_done: got %b want 010", {busy, hostWriteReady, memoryWriteRequest});
    else passed++;
  endtask

  task automatic test_read_latency();
    int t;
    apply_reset();
    memoryReadData = 8'hC3; hostReadValid = 1'b1; hostReadAddress = 17'h00010;
    checks++;
    if (hostReadReady !== 1'b1) $display("FAIL read_ready: got %b want 1", hostReadReady);
    else passed++;
    tick();
    hostReadValid = 1'b0;
    t = 1;
    while (hostReadDataValid !== 1'b1 && t < 20) begin tick(); t++; end
    checks++;
    if (t !== READ_WAIT + 1) $display("FAIL read_latency: got %0d want %0d", t, READ_WAIT + 1);
    else passed++;
    checks++;
    if ({hostReadData, memoryReadAddress} !== {8'hC3, 17'h00010})
      $display("FAIL read_data: got %h/%h want c3/00010", hostReadData, memoryReadAddress);
    else passed++;
    tick();
    checks++;
    if ({hostReadDataValid, hostReadReady, memoryReadAddress} !== {1'b0, 1'b1, 17'h00010})
      $display("FAIL read_pulse: got %b/%b/%h want 0/1/00010",
               hostReadDataValid, hostReadReady, memoryReadAddress);
    else passed++;
  endtask

  task automatic test_raw_order();
    int n;
    apply_reset();
    hostWriteValid = 1'b1; hostWriteAddress = 17'h00020; hostWriteData = 8'h11;
    tick();
    hostWriteValid = 1'b0;
    hostReadValid = 1'b1; hostReadAddress = 17'h00020;
    n = 0;
    while (hostReadReady !== 1'b1 && n < 20) begin
      memoryWriteComplete = (memoryWriteRequest === 1'b1);
      tick();
      n++;
    end
    memoryWriteComplete = 1'b0;
    // Not ready while queued (1), while requesting (1), during the gap (1).
    checks++;
    if (n !== 3) $display("FAIL raw_wait: got %0d want 3", n);
    else passed++;
    checks++;
    if ({memoryWriteRequest, busy} !== 2'b00)
      $display("FAIL raw_write_done: got %b want 00", {memoryWriteRequest, busy});
    else passed++;
    tick();
    hostReadValid = 1'b0;
    n = 0;
    while (hostReadDataValid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if ({hostReadDataValid, memoryReadAddress} !== {1'b1, 17'h00020})
      $display("FAIL raw_read: got %b/%h want 1/00020", hostReadDataValid, memoryReadAddress);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      hostWriteValid = 1'b1; hostWriteAddress = 17'h00300 + 17'(i); hostWriteData = 8'hA0 + 8'(i);
      tick();
    end
    hostWriteValid = 1'b0;
    checks++;
    if ({memoryWriteRequest, busy} !== 2'b11)
      $display("FAIL mid_req_on: got %b want 11", {memoryWriteRequest, busy});
    else passed++;
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({memoryWriteRequest, busy, hostWriteReady, hostReadReady} !== 4'b0011)
      $display("FAIL mid_async: got %b want 0011",
               {memoryWriteRequest, busy, hostWriteReady, hostReadReady});
    else passed++;
    @(negedge clock);
    resetN = 1'b1;
    memoryWriteComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    checks++;
    if ({memoryWriteRequest, busy, hostWriteReady, hostReadReady} !== 4'b0011)
      $display("FAIL mid_late_complete: got %b want 0011",
               {memoryWriteRequest, busy, hostWriteReady, hostReadReady});
    else passed++;
    repeat (3) tick();
    checks++;
    if ({memoryWriteRequest, busy} !== 2'b00)
      $display("FAIL mid_stays_idle: got %b want 00", {memoryWriteRequest, busy});
    else passed++;
  endtask

  task automatic test_simultaneous();
    int n;
    bit early;
    apply_reset();
    hostWriteValid = 1'b1; hostWriteAddress = 17'h0AAAA; hostWriteData = 8'h77;
    hostReadValid  = 1'b1; hostReadAddress  = 17'h00055; memoryReadData = 8'h9E;
    checks++;
    if ({hostWriteReady, hostReadReady} !== 2'b11)
      $display("FAIL sim_ready: got %b want 11", {hostWriteReady, hostReadReady});
    else passed++;
    tick();
    hostWriteValid = 1'b0; hostReadValid = 1'b0;
    n = 0; early = 1'b0;
    while (hostReadDataValid !== 1'b1 && n < 20) begin
      if (memoryWriteRequest === 1'b1) early = 1'b1;
      tick();
      n++;
    end
    checks++;
    if ({early, memoryWriteRequest, hostReadDataValid, hostReadData} !== {1'b0, 1'b0, 1'b1, 8'h9E})
      $display("FAIL sim_read_first: got early=%b req=%b vld=%b data=%h want 0/0/1/9e",
               early, memoryWriteRequest, hostReadDataValid, hostReadData);
    else passed++;
    tick();
    checks++;
    if ({memoryWriteRequest, memoryWriteAddress, memoryWriteData} !== {1'b1, 17'h0AAAA, 8'h77})
      $display("FAIL sim_write_after: got %b/%h/%h want 1/0aaaa/77",
               memoryWriteRequest, memoryWriteAddress, memoryWriteData);
    else passed++;
    memoryWriteComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) $display("FAIL sim_done: got busy=%b want 0", busy);
    else passed++;
  endtask

  // Random traffic against a transaction-level model: writes retire in
  // order through a request/complete handshake with one idle cycle after
  // each; a read is admitted only with nothing pending and returns the
  // byte on memoryReadData READ_WAIT edges after acceptance.
  task automatic test_random();
    ent_t        wq[$];
    bit          wr_act, gap, rd_pend, exp_v, m_wr, m_rr, acc_w, acc_r, start;
    int          rd_t, wp, fails0;
    logic [16:0] exp_ra, exp_wa;
    logic [7:0]  exp_rd, exp_wd;
    logic [54:0] obs, expv;
    apply_reset();
    wr_act = 0; gap = 0; rd_pend = 0; exp_v = 0; rd_t = 0;
    exp_ra = '0; exp_wa = '0; exp_rd = '0; exp_wd = '0;
    fails0 = 0;
    for (int k = 0; k < 3000; k++) begin
      m_wr = (wq.size() < FIFO_DEPTH);
      m_rr = !rd_pend && (wq.size() == 0) && !gap;
      obs  = {hostWriteReady, hostReadReady, busy, memoryWriteRequest, memoryWriteAddress,
              memoryWriteData, hostReadDataValid, hostReadData, memoryReadAddress};
      expv = {m_wr, m_rr, (wq.size() != 0) || gap || rd_pend, wr_act, exp_wa,
              exp_wd, exp_v, exp_rd, exp_ra};
      checks++;
      if (obs !== expv) begin
        $display("FAIL random[%0d]: got %h want %h", k, obs, expv);
        fails0++;
      end else passed++;
      if (fails0 > 20) break;

      wp = ((k / 150) % 2 == 1) ? 5 : 35;
      hostWriteValid      = ($urandom_range(0, 99) < wp);
      hostWriteAddress    = 17'($urandom);
      hostWriteData       = 8'($urandom);
      hostReadValid       = ($urandom_range(0, 99) < 25);
      hostReadAddress     = 17'($urandom);
      memoryWriteComplete = ($urandom_range(0, 99) < 30);
      memoryReadData      = 8'($urandom);

      acc_w = hostWriteValid && m_wr;
      acc_r = hostReadValid && m_rr;
      start = !wr_act && !gap && (wq.size() > 0) && !rd_pend;
      exp_v = 0;
      gap   = 0;
      if (wr_act && memoryWriteComplete) begin
        void'(wq.pop_front());
        wr_act = 0;
        gap    = 1;
      end else if (start) begin
        wr_act = 1;
        exp_wa = wq[0].a;
        exp_wd = wq[0].d;
      end
      if (rd_pend) begin
        rd_t++;
        if (rd_t == READ_WAIT) begin
          exp_v   = 1;
          exp_rd  = memoryReadData;
          rd_pend = 0;
        end
      end
      if (acc_r) begin
        rd_pend = 1;
        rd_t    = 0;
        exp_ra  = hostReadAddress;
      end
      if (acc_w) wq.push_back({hostWriteAddress, hostWriteData});
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_write();
    test_fifo_full();
    test_read_latency();
    test_raw_order();
    test_reset_mid_write();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end

endmodule
